pipe_slice: RTL

Parametrised, fully registered valid/ready pipeline slice carrying a `DATA_W`-bit payload. It is the general successor to the single-bit valid stage between pipeline stages in the core (IF→ID, ID→EX, …). It adds a data path and a two-entry skid buffer, so that both `ready_o` and `valid_ro` come from flops while throughput stays at one beat per cycle. An optional synchronous flush lets the pipeline be cleared on branch redirect or trap.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_slice_ctrl.sv | 117 +++++++++++
 rtl/pipe_slice.sv | 64 ++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline slice: state encoding and
// occupancy width.
package pipe_pkg;

    // Occupancy counter width (0, 1 or 2 beats held).
    localparam int PIPE_OCC_W = 2;

    // Slice state. Encoding 2'd3 is illegal and recovers to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_slice_ctrl.sv
// Control FSM for pipe_slice. Tracks how many beats are held (main + skid)
// and produces the handshake outputs plus the payload load controls.
// Outputs are decoded purely from the state flops, so neither ready_o nor
// valid_ro has a combinational path from ready_i or valid_i.
// Optional macro PIPE_SLICE_FLUSH_EN adds the synchronous flush_i input.
module pipe_slice_ctrl
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  ready_i,
`ifdef PIPE_SLICE_FLUSH_EN
    input  logic                  flush_i,
`endif
    output logic                  ready_o,
    output logic                  valid_ro,
    output logic [PIPE_OCC_W-1:0] occ_o,
    output logic                  main_ld,
    output logic                  skid_ld,
    output logic                  main_sel_skid
);

    pipe_state_e state_q;
    pipe_state_e state_d;
    logic        in_hs;
    logic        out_hs;

    assign in_hs  = valid_i & ready_o;
    assign out_hs = valid_ro & ready_i;

    // Decode handshake outputs and occupancy from the current state only.
    always_comb begin
        valid_ro = 1'b0;
        ready_o  = 1'b0;
        occ_o    = 2'd0;
        case (state_q)
            EMPTY: begin
                valid_ro = 1'b0;
                ready_o  = 1'b1;
                occ_o    = 2'd0;
            end
            BUSY: begin
                valid_ro = 1'b1;
                ready_o  = 1'b1;
                occ_o    = 2'd1;
            end
            FULL: begin
                valid_ro = 1'b1;
                ready_o  = 1'b0;
                occ_o    = 2'd2;
            end
            default: begin
                // Illegal encoding: accept nothing, deliver nothing.
                valid_ro = 1'b0;
                ready_o  = 1'b0;
                occ_o    = 2'd0;
            end
        endcase
    end

    // Next-state and payload load-enable logic.
    always_comb begin
        state_d       = state_q;
        main_ld       = 1'b0;
        skid_ld       = 1'b0;
        main_sel_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    main_ld = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_hs && out_hs) begin
                    main_ld = 1'b1;
                end else if (in_hs) begin
                    // Downstream stalled: park the in-flight beat in the skid.
                    skid_ld = 1'b1;
                    state_d = FULL;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_hs) begin
                    main_ld       = 1'b1;
                    main_sel_skid = 1'b1;
                    state_d       = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
`ifdef PIPE_SLICE_FLUSH_EN
        // Flush wins over everything; the main register keeps its value.
        if (flush_i) begin
            state_d       = EMPTY;
            main_ld       = 1'b0;
            skid_ld       = 1'b0;
            main_sel_skid = 1'b0;
        end
`endif
    end

    // State register with asynchronous reset to EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pipe_slice.sv
// Fully registered valid/ready pipeline slice with a two-entry skid buffer.
// Sustains one beat per cycle while both ready_o and valid_ro come from
// flops. Define PIPE_SLICE_FLUSH_EN to add the synchronous flush_i port.
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic                  ready_o,
    output logic                  valid_ro,
    output logic [DATA_W-1:0]     data_ro,
    input  logic                  ready_i,
`ifdef PIPE_SLICE_FLUSH_EN
    input  logic                  flush_i,
`endif
    output logic [PIPE_OCC_W-1:0] occ_o
);

    logic              main_ld;
    logic              skid_ld;
    logic              main_sel_skid;
    logic [DATA_W-1:0] main_p0;
    logic [DATA_W-1:0] skid_p0;

    pipe_slice_ctrl u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .ready_i       (ready_i),
`ifdef PIPE_SLICE_FLUSH_EN
        .flush_i       (flush_i),
`endif
        .ready_o       (ready_o),
        .valid_ro      (valid_ro),
        .occ_o         (occ_o),
        .main_ld       (main_ld),
        .skid_ld       (skid_ld),
        .main_sel_skid (main_sel_skid)
    );

    // Main register: loads a new beat from upstream or refills from the skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_p0 <= RST_DATA;
        end else if (main_ld) begin
            main_p0 <= main_sel_skid ? skid_p0 : data_i;
        end
    end

    // Skid register: catches the beat in flight when the output stalls; no reset.
    always_ff @(posedge clk) begin
        if (skid_ld) begin
            skid_p0 <= data_i;
        end
    end

    assign data_ro = main_p0;

endmodule
